// File: rtl/stage_if_pkg.sv
// Shared RV32I fetch definitions: data width, bubble encoding and fetch FSM states.
package stage_if_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/stage_if_pipe_reg.sv
// IF/ID pipeline register: loads {inst,pc,pc+4,valid}, flushes to a bubble, or holds.
// Reset leaves a bubble at RESET_PC; en=0 freezes the register.
module pipe_reg_ifid
  import stage_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] inst_q, pc_q, pc4_q;
  logic            valid_q;

  // A bubble keeps pc/pc4 so decode still sees a sensible PC alongside the NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + PC_STEP;
      valid_q <= 1'b0;
    end else if (en_i) begin
      if (bubble_i) begin
        inst_q  <= NOP_INST;
        valid_q <= 1'b0;
      end else if (load_i) begin
        inst_q  <= inst_i;
        pc_q    <= pc_i;
        pc4_q   <= pc_i + PC_STEP;
        valid_q <= 1'b1;
      end
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/stage_if.sv
// Instruction fetch with one outstanding imem request; 2-cycle latency from request to IF/ID.
// Stall parks a returned word in a hold buffer; a redirect flushes IF/ID and discards stale responses.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic [XLEN-1:0] ifid_inst,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc4,
  output logic            ifid_valid,
  output logic            misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            discard_q, discard_d;
  logic            misalign_q, misalign_d;
  logic            ifid_load, ifid_bubble;
  logic [XLEN-1:0] ifid_inst_d;
  logic            req_fire;

  assign imem_req_valid = en && (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign misalign_err   = misalign_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    discard_d   = discard_q;
    misalign_d  = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_inst_d = imem_resp_data;

    if (redirect_valid) begin
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_d  = |redirect_pc[1:0];
      ifid_bubble = 1'b1;
      hold_d      = NOP_INST;
      case (state_q)
        // Without a response yet, the in-flight fetch must be swallowed when it lands.
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (!stall) begin
              ifid_load = 1'b1;
              pc_d      = pc_q + PC_STEP;
              state_d   = S_REQ;
            end else begin
              hold_d  = imem_resp_data;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_load   = 1'b1;
            ifid_inst_d = hold_q;
            pc_d        = pc_q + PC_STEP;
            state_d     = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
      if (!ifid_load && !stall) ifid_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      hold_q     <= NOP_INST;
      discard_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
    end
  end

  pipe_reg_ifid #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .inst_i   (ifid_inst_d),
    .pc_i     (pc_q),
    .inst_o   (ifid_inst),
    .pc_o     (ifid_pc),
    .pc4_o    (ifid_pc4),
    .valid_o  (ifid_valid)
  );

endmodule

// File: tb/tb_stage_if.sv
// Directed scenarios plus a randomized run scored against a fetch-stream model and memory model.
module tb_stage_if;

  logic        clk, rst, en, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] ifid_inst, ifid_pc, ifid_pc4;
  logic        ifid_valid, misalign_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  stage_if dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .ifid_inst(ifid_inst), .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a cheap address-dependent word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0013;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    step();
    step();
    checks++; if (ifid_inst !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", ifid_inst, NOP); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0 || ifid_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc got %h/%h want 0/4", ifid_pc, ifid_pc4); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_fetch;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0513;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_wait_noreq got %b want 0", imem_req_valid); end
    step();
    imem_resp_valid = 1'b0;
    checks++; if (ifid_inst !== 32'h0020_0513 || ifid_valid !== 1'b1) begin errors++; $display("FAIL fetch_inst got %h/%b want 00200513/1", ifid_inst, ifid_valid); end
    checks++; if (ifid_pc !== 32'h0 || ifid_pc4 !== 32'h4) begin errors++; $display("FAIL fetch_pc got %h/%h want 0/4", ifid_pc, ifid_pc4); end
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin errors++; $display("FAIL fetch_next_req got %b/%h want 1/4", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stall;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h00A0_0593; stall = 1'b1;
    step();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_noreq[%0d] got %b want 0", i, imem_req_valid); end
      checks++; if (ifid_valid !== 1'b0 || ifid_inst !== NOP) begin errors++; $display("FAIL stall_hold[%0d] got %h/%b want %h/0", i, ifid_inst, ifid_valid, NOP); end
      step();
    end
    stall = 1'b0;
    step();
    checks++; if (ifid_inst !== 32'h00A0_0593 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_release got %h/%b want 00a00593/1", ifid_inst, ifid_valid); end
    checks++; if (ifid_pc !== 32'h4 || ifid_pc4 !== 32'h8) begin errors++; $display("FAIL stall_release_pc got %h/%h want 4/8", ifid_pc, ifid_pc4); end
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin errors++; $display("FAIL stall_next_req got %b/%h want 1/8", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0BAD_F00D;
    checks++; if (ifid_valid !== 1'b0 || ifid_inst !== NOP) begin errors++; $display("FAIL redir_bubble got %h/%b want %h/0", ifid_inst, ifid_valid, NOP); end
    step();
    imem_resp_valid = 1'b0;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_drop got valid %b inst %h want 0", ifid_valid, ifid_inst); end
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_req got %b/%h want 1/100", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_misalign;
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h102;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL misal_noreq got %b want 0", imem_req_valid); end
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misal_pulse got %b want 1", misalign_err); end
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL misal_req got %b/%h want 1/100", imem_req_valid, imem_req_addr); end
    step();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misal_clear got %b want 0", misalign_err); end
  endtask

  task automatic test_redirect_hold;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111; stall = 1'b1;
    step();
    imem_resp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || ifid_inst !== NOP) begin errors++; $display("FAIL hold_redir_bubble got %h/%b want %h/0", ifid_inst, ifid_valid, NOP); end
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL hold_redir_req got %b/%h want 1/200", imem_req_valid, imem_req_addr); end
    stall = 1'b0;
    step();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL hold_cleared got valid %b inst %h want 0", ifid_valid, ifid_inst); end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0030_0613;
    step();
    imem_resp_valid = 1'b0;
    checks++; if (ifid_inst !== 32'h0030_0613 || ifid_pc !== 32'h200 || ifid_valid !== 1'b1) begin errors++; $display("FAIL hold_refetch got %h/%h/%b want 00300613/200/1", ifid_inst, ifid_pc, ifid_valid); end
  endtask

  task automatic test_reset_wait;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; en = 1'b0; rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL en0_noreq got %b want 0", imem_req_valid); end
    step();
    rst = 1'b0; en = 1'b1;
    checks++; if (ifid_valid !== 1'b0 || ifid_inst !== NOP || ifid_pc !== 32'h0) begin errors++; $display("FAIL rstwait_ifid got %h/%h/%b want %h/0/0", ifid_inst, ifid_pc, ifid_valid, NOP); end
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL rstwait_req got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got %h want fffffffc", imem_req_addr); end
    step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
    step();
    imem_resp_valid = 1'b0;
    checks++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL wrap_ifid got %h/%h/%b want fffffffc/0/1", ifid_pc, ifid_pc4, ifid_valid); end
    #1;
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", imem_req_addr); end
  endtask

  // Model: fetch addresses run sequentially from the last request or restart at the last
  // redirect target; a redirect kills every fetch not yet delivered; deliveries come in order.
  task automatic test_random;
    logic [31:0] live[$];
    logic [31:0] last_addr, redir_tgt, want, got_addr;
    logic        redir_since, exp_mis, prev_valid, pend;
    logic [31:0] prev_pc, pend_addr;
    int          pend_cnt, deliveries;
    rst = 1'b1; en = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    step();
    rst = 1'b0;
    last_addr = '0; redir_since = 1'b1; redir_tgt = 32'h0; exp_mis = 1'b0;
    prev_valid = 1'b0; prev_pc = '0; pend = 1'b0; pend_addr = '0; pend_cnt = 0; deliveries = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) step();
      if (ifid_valid && (!prev_valid || ifid_pc !== prev_pc)) begin
        deliveries++;
        want = (live.size() > 0) ? live.pop_front() : 32'hDEAD_0001;
        checks++; if (ifid_pc !== want) begin errors++; $display("FAIL rnd_deliver_pc cyc %0d got %h want %h", cyc, ifid_pc, want); end
        checks++; if (ifid_inst !== mem_word(ifid_pc) || ifid_pc4 !== ifid_pc + 32'd4) begin errors++; $display("FAIL rnd_deliver_data cyc %0d got %h/%h want %h/%h", cyc, ifid_inst, ifid_pc4, mem_word(ifid_pc), ifid_pc + 32'd4); end
      end
      checks++; if (misalign_err !== exp_mis) begin errors++; $display("FAIL rnd_misalign cyc %0d got %b want %b", cyc, misalign_err, exp_mis); end
      prev_valid = ifid_valid; prev_pc = ifid_pc;

      imem_resp_valid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_resp_valid = 1'b1; imem_resp_data = mem_word(pend_addr); pend = 1'b0;
        end
      end
      en = (pend || imem_resp_valid) ? 1'b1 : ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 9) < 3);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom() : {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      #1;
      if (en) begin
        if (redirect_valid) begin
          checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rnd_req_on_redirect cyc %0d got 1 want 0", cyc); end
        end
        if (imem_req_valid && imem_req_ready) begin
          got_addr = imem_req_addr;
          want = redir_since ? redir_tgt : last_addr + 32'd4;
          checks++; if (got_addr !== want) begin errors++; $display("FAIL rnd_req_addr cyc %0d got %h want %h", cyc, got_addr, want); end
          last_addr = want; redir_since = 1'b0;
          live.push_back(want);
          pend = 1'b1; pend_addr = got_addr; pend_cnt = $urandom_range(1, 3);
        end
        if (redirect_valid) begin
          live.delete();
          redir_since = 1'b1;
          redir_tgt = {redirect_pc[31:2], 2'b00};
          exp_mis = |redirect_pc[1:0];
        end else begin
          exp_mis = 1'b0;
        end
      end else begin
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rnd_en0_req cyc %0d got 1 want 0", cyc); end
      end
    end
    en = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    checks++; if (deliveries < 100) begin errors++; $display("FAIL rnd_progress got %0d deliveries want >= 100", deliveries); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_misalign();
    test_redirect_hold();
    test_reset_wait();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
